// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for the boot loader.
// The loader connects through the slave modport, the stream source through master.
interface imem_loader_if #(
    parameter int ADDR_W  = 15,
    parameter int I_WIDTH = 32
);
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [I_WIDTH-1:0] im_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Parses LEN_LO, LEN_HI, N little-endian words and a trailing XOR checksum.
module imem_loader #(
    parameter int I_WIDTH = 32,
    parameter int IMEM_SZ = 2**15,
    parameter int ADDR_W  = $clog2(IMEM_SZ)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
        S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [15:0]        len_q, len_d;
    logic [16:0]        widx_q, widx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [I_WIDTH-1:0] asm_q, asm_d;
    logic [7:0]         csum_q, csum_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [I_WIDTH-1:0] wdata_q, wdata_d;

    logic        ready;
    logic        xfer;
    logic        start_ok;
    logic [15:0] n_full;
    logic        too_big;
    logic        word_end;
    logic        last_word;

    assign xfer      = bus.byte_valid & ready;
    assign start_ok  = start & ((state_q == S_IDLE) |
                                (state_q == S_DONE) |
                                (state_q == S_ERR));
    assign n_full    = {bus.byte_data, len_lo_q};
    assign too_big   = {16'd0, n_full} > 32'(IMEM_SZ);
    assign word_end  = (bcnt_q == 2'd3);
    assign last_word = (widx_q + 17'd1) == {1'b0, len_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only honoured when no load is running
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (too_big)             state_d = S_ERR;
                    else if (n_full == '0)   state_d = S_CSUM;
                    else                     state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && word_end && last_word) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (xfer) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state; busy also covers the trailing write
    always_comb begin
        ready = (state_q == S_LEN_LO) | (state_q == S_LEN_HI) |
                (state_q == S_DATA)   | (state_q == S_CSUM);
        busy  = ready | we_q;
        done  = (state_q == S_DONE);
        err   = (state_q == S_ERR);
    end

    assign bus.byte_ready = ready;
    assign bus.im_we      = we_q;
    assign bus.im_addr    = addr_q;
    assign bus.im_wdata   = wdata_q;

    // Datapath: length capture, word assembly, checksum and write strobe
    always_comb begin
        len_lo_d = len_lo_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (start_ok) begin
            len_lo_d = '0;
            len_d    = '0;
            widx_d   = '0;
            bcnt_d   = '0;
            asm_d    = '0;
            csum_d   = '0;
        end else if (xfer) begin
            unique case (state_q)
                S_LEN_LO: len_lo_d = bus.byte_data;
                S_LEN_HI: len_d    = n_full;
                S_DATA: begin
                    asm_d[{bcnt_q, 3'b000} +: 8] = bus.byte_data;
                    csum_d = csum_q ^ bus.byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (word_end) begin
                        we_d    = 1'b1;
                        wdata_d = {bus.byte_data, asm_q[23:0]};
                        addr_d  = widx_q[ADDR_W-1:0];
                        widx_d  = widx_q + 17'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; reset drops any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_q <= '0;
            len_q    <= '0;
            widx_q   <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            csum_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            asm_q    <= asm_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// DUT 0 uses the default depth, DUT 1 a depth of four words.
module tb_imem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      start;
    logic [1:0]      bv;
    logic [1:0][7:0] bd;

    logic [1:0]       rdy, we, bsy, dn, er;
    logic [1:0][14:0] addr;
    logic [1:0][31:0] wd;

    imem_loader_if #(.ADDR_W(15)) if0 ();
    imem_loader_if #(.ADDR_W(2))  if1 ();

    assign if0.byte_valid = bv[0];
    assign if0.byte_data  = bd[0];
    assign if1.byte_valid = bv[1];
    assign if1.byte_data  = bd[1];
    assign rdy  = {if1.byte_ready, if0.byte_ready};
    assign we   = {if1.im_we, if0.im_we};
    assign addr[0] = if0.im_addr;
    assign addr[1] = {13'd0, if1.im_addr};
    assign wd[0]   = if0.im_wdata;
    assign wd[1]   = if1.im_wdata;

    imem_loader u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .bus(if0),
        .busy(bsy[0]), .done(dn[0]), .err(er[0])
    );

    imem_loader #(.IMEM_SZ(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .bus(if1),
        .busy(bsy[1]), .done(dn[1]), .err(er[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wr0 = 0;
    int wr1 = 0;
    logic [46:0] q0[$];
    logic [46:0] q1[$];

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [46:0] e;
        if (we[0]) begin
            wr0++;
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL wr0_unexpected addr=%h data=%h", addr[0], wd[0]);
            end else begin
                e = q0.pop_front();
                if ({addr[0], wd[0]} !== e) begin
                    n_fail++;
                    $display("FAIL wr0 got %h/%h exp %h/%h",
                             addr[0], wd[0], e[46:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [46:0] e;
        if (we[1]) begin
            wr1++;
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL wr1_unexpected addr=%h data=%h", addr[1], wd[1]);
            end else begin
                e = q1.pop_front();
                if ({addr[1], wd[1]} !== e) begin
                    n_fail++;
                    $display("FAIL wr1 got %h/%h exp %h/%h",
                             addr[1], wd[1], e[46:32], e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start(input int s);
        @(negedge clk);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input int gap);
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        @(negedge clk);
        bv[s] = 1'b0;
        repeat (gap) @(negedge clk);
        bv[s] = 1'b1;
        bd[s] = b;
        while (!ok && n < 20) begin
            if (rdy[s]) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        #1 bv[s] = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte_timeout dut=%0d byte=%h ready=%b exp 1", s, b, rdy[s]);
        end
    endtask

    // Streams one load; csum_ovr < 0 sends the correct checksum
    task automatic run_load(input int s, input logic [31:0] words[$],
                            input int csum_ovr, input int gap, input int inject_at);
        logic [7:0]  cs;
        logic [15:0] n;
        int          w;
        cs = 8'h00;
        n  = 16'(words.size());
        if (s == 0) wr0 = 0;
        else        wr1 = 0;
        pulse_start(s);
        send_byte(s, n[7:0], $urandom_range(gap, 0));
        send_byte(s, n[15:8], $urandom_range(gap, 0));
        for (w = 0; w < words.size(); w++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] wv;
                wv = words[w];
                if (w * 4 + k == inject_at) pulse_start(s);
                send_byte(s, wv[k*8 +: 8], $urandom_range(gap, 0));
                cs = cs ^ wv[k*8 +: 8];
            end
            if (s == 0) q0.push_back({15'(w), words[w]});
            else        q1.push_back({15'(w), words[w]});
        end
        send_byte(s, (csum_ovr < 0) ? cs : 8'(csum_ovr), $urandom_range(gap, 0));
        for (int i = 0; i < 10 && !(dn[s] || er[s]); i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_end(input string nm, input int s,
                             input logic exp_dn, input logic exp_er, input int exp_wr);
        int wr;
        int ql;
        wr = (s == 0) ? wr0 : wr1;
        ql = (s == 0) ? q0.size() : q1.size();
        n_tests++;
        if (dn[s] !== exp_dn || er[s] !== exp_er) begin
            n_fail++;
            $display("FAIL %s_status done=%b err=%b exp %b %b", nm, dn[s], er[s], exp_dn, exp_er);
        end
        n_tests++;
        if (bsy[s] !== 1'b0 || rdy[s] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle busy=%b ready=%b exp 0 0", nm, bsy[s], rdy[s]);
        end
        n_tests++;
        if (wr !== exp_wr || ql !== 0) begin
            n_fail++;
            $display("FAIL %s_writes got %0d left %0d exp %0d left 0", nm, wr, ql, exp_wr);
        end
    endtask

    task automatic check_zero(input string nm, input int s);
        n_tests++;
        if ({rdy[s], we[s], bsy[s], dn[s], er[s]} !== 5'b0 ||
            addr[s] !== 15'd0 || wd[s] !== 32'd0) begin
            n_fail++;
            $display("FAIL %s rdy/we/busy/done/err=%b addr=%h data=%h exp all 0",
                     nm, {rdy[s], we[s], bsy[s], dn[s], er[s]}, addr[s], wd[s]);
        end
    endtask

    logic [31:0] nom[$];
    logic [31:0] none[$];
    logic [31:0] four[$];

    task automatic test_reset();
        #12;
        check_zero("reset0", 0);
        check_zero("reset1", 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("post_reset0", 0);
    endtask

    task automatic test_nominal();
        run_load(0, nom, -1, 0, -1);
        check_end("nominal", 0, 1'b1, 1'b0, 2);
    endtask

    task automatic test_empty();
        run_load(0, none, -1, 0, -1);
        check_end("empty", 0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_bad_csum();
        run_load(0, nom, 8'h81, 0, -1);
        check_end("bad_csum", 0, 1'b0, 1'b1, 2);
    endtask

    task automatic test_oversize();
        wr1 = 0;
        pulse_start(1);
        send_byte(1, 8'h05, 0);
        send_byte(1, 8'h00, 0);
        @(negedge clk);
        n_tests++;
        if (er[1] !== 1'b1 || rdy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize err=%b ready=%b exp 1 0", er[1], rdy[1]);
        end
        repeat (3) @(negedge clk);
        check_end("oversize", 1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_full_depth();
        run_load(1, four, -1, 0, -1);
        check_end("full_depth", 1, 1'b1, 1'b0, 4);
    endtask

    task automatic test_stall();
        run_load(0, nom, -1, 3, 5);
        check_end("stall", 0, 1'b1, 1'b0, 2);
    endtask

    task automatic test_reset_mid();
        wr0 = 0;
        pulse_start(0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h00, 0);
        send_byte(0, 8'h13, 0);
        send_byte(0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("mid_release", 0);
        run_load(0, nom, -1, 0, -1);
        check_end("after_reset", 0, 1'b1, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        run_load(0, four, -1, 0, -1);
        check_end("b2b_a", 0, 1'b1, 1'b0, 4);
        run_load(0, nom, -1, 1, -1);
        check_end("b2b_b", 0, 1'b1, 1'b0, 2);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        bv    = '0;
        bd    = '0;
        nom   = '{32'h00000013, 32'h00100093};
        four  = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfeedface};
        test_reset();
        test_nominal();
        test_empty();
        test_bad_csum();
        test_oversize();
        test_full_depth();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
